// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : In-order pipeline controller with a RAW register scoreboard and
//            a branch-sequencing FSM (RUN / BR_WAIT / FLUSH).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int NUM_REGS    = 16,
    parameter int REG_ADDR_W  = 4,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  dec_valid_i,
    input  logic [REG_ADDR_W-1:0] dec_src1_i,
    input  logic                  dec_src1_used_i,
    input  logic [REG_ADDR_W-1:0] dec_src2_i,
    input  logic                  dec_src2_used_i,
    input  logic                  dec_wr_i,
    input  logic [REG_ADDR_W-1:0] dec_dst_i,
    input  logic                  dec_branch_i,
    input  logic                  alu_br_valid_i,
    input  logic                  alu_br_taken_i,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_dst_i,
    output logic                  fetch_keep_o,
    output logic                  decode_keep_o,
    output logic                  reg_nope_o,
    output logic                  flush_o,
    output logic                  issue_o,
    output logic [NUM_REGS-1:0]   busy_map_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam int c_FC_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
    localparam logic [c_FC_W-1:0] c_FLUSH_LOAD = c_FC_W'(FLUSH_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_FC_W-1:0]   r_flush_cnt;
    logic [c_FC_W-1:0]   w_flush_cnt_nxt;
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [NUM_REGS-1:0] w_wb_clr;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_busy_eff;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic                w_hazard;
    logic                w_issue;
    logic                w_keep;
    logic                w_nope;
    logic                w_flush;
    logic                w_fetch_keep;

    // Write-through register file: a same-cycle writeback already satisfies the read.
    always_comb begin
        w_wb_clr = '0;
        w_set    = '0;
        if (wb_valid_i) begin
            w_wb_clr[wb_dst_i] = 1'b1;
        end
        if (w_issue && dec_wr_i) begin
            w_set[dec_dst_i] = 1'b1;
        end
    end

    assign w_busy_eff = r_busy & ~w_wb_clr;
    assign w_hazard   = dec_valid_i &
                        ((dec_src1_used_i & w_busy_eff[dec_src1_i]) |
                         (dec_src2_used_i & w_busy_eff[dec_src2_i]));

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_sb
        if (i == 0) begin : g_r0
            assign w_busy_nxt[i] = 1'b0;
        end else begin : g_rn
            // A newly issued writer outranks the retiring one.
            assign w_busy_nxt[i] = w_set[i] | (r_busy[i] & ~w_wb_clr[i]);
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
            r_busy      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_issue         = 1'b0;
        w_fetch_keep    = 1'b0;
        w_keep          = 1'b0;
        w_nope          = 1'b0;
        w_flush         = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_issue      = arstn & dec_valid_i & ~w_hazard;
                w_fetch_keep = w_hazard;
                w_keep       = w_hazard;
                w_nope       = w_hazard;
                if (w_issue && dec_branch_i) begin
                    w_state_nxt = ST_BR_WAIT;
                end
            end
            ST_BR_WAIT: begin
                w_fetch_keep = 1'b1;
                w_keep       = 1'b1;
                w_nope       = 1'b1;
                if (alu_br_valid_i) begin
                    if (alu_br_taken_i) begin
                        w_state_nxt     = ST_FLUSH;
                        w_flush_cnt_nxt = c_FLUSH_LOAD;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_FLUSH: begin
                w_flush = 1'b1;
                w_nope  = 1'b1;
                if (r_flush_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - c_FC_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Outputs are forced low while reset is asserted, independent of inputs.
    assign fetch_keep_o  = arstn & w_fetch_keep;
    assign decode_keep_o = arstn & w_keep;
    assign reg_nope_o    = arstn & w_nope;
    assign flush_o       = arstn & w_flush;
    assign issue_o       = w_issue;
    assign busy_map_o    = r_busy;
    assign stall_cnt_o   = r_stall_cnt;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_stall_cnt <= '0;
        end else if (fetch_keep_o && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed, table-driven self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        arstn;
    logic        dec_valid_i, dec_src1_used_i, dec_src2_used_i, dec_wr_i, dec_branch_i;
    logic [3:0]  dec_src1_i, dec_src2_i, dec_dst_i, wb_dst_i;
    logic        alu_br_valid_i, alu_br_taken_i, wb_valid_i;
    logic        fetch_keep_o, decode_keep_o, reg_nope_o, flush_o, issue_o;
    logic [15:0] busy_map_o;
    logic [3:0]  stall_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .NUM_REGS   (16),
        .REG_ADDR_W (4),
        .FLUSH_DEPTH(2),
        .CNT_W      (4)
    ) dut (
        .clk            (clk),
        .arstn          (arstn),
        .dec_valid_i    (dec_valid_i),
        .dec_src1_i     (dec_src1_i),
        .dec_src1_used_i(dec_src1_used_i),
        .dec_src2_i     (dec_src2_i),
        .dec_src2_used_i(dec_src2_used_i),
        .dec_wr_i       (dec_wr_i),
        .dec_dst_i      (dec_dst_i),
        .dec_branch_i   (dec_branch_i),
        .alu_br_valid_i (alu_br_valid_i),
        .alu_br_taken_i (alu_br_taken_i),
        .wb_valid_i     (wb_valid_i),
        .wb_dst_i       (wb_dst_i),
        .fetch_keep_o   (fetch_keep_o),
        .decode_keep_o  (decode_keep_o),
        .reg_nope_o     (reg_nope_o),
        .flush_o        (flush_o),
        .issue_o        (issue_o),
        .busy_map_o     (busy_map_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    // ctl = {fetch_keep, decode_keep, reg_nope, flush, issue}
    typedef struct {
        logic       v;
        logic [3:0] s1;
        logic       s1u;
        logic [3:0] s2;
        logic       s2u;
        logic       wr;
        logic [3:0] dst;
        logic       br;
        logic       abv;
        logic       abt;
        logic       wbv;
        logic [3:0] wbd;
        logic [4:0] ctl;
        logic [15:0] busy;
        logic [3:0] stall;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic v, input logic [3:0] s1, input logic s1u,
                                input logic [3:0] s2, input logic s2u, input logic wr,
                                input logic [3:0] dst, input logic br, input logic abv,
                                input logic abt, input logic wbv, input logic [3:0] wbd,
                                input logic [4:0] ctl, input logic [15:0] busy,
                                input logic [3:0] stall);
        vec_t t;
        t.v = v; t.s1 = s1; t.s1u = s1u; t.s2 = s2; t.s2u = s2u; t.wr = wr;
        t.dst = dst; t.br = br; t.abv = abv; t.abt = abt; t.wbv = wbv; t.wbd = wbd;
        t.ctl = ctl; t.busy = busy; t.stall = stall;
        tbl.push_back(t);
    endfunction

    task automatic drive(input vec_t t);
        dec_valid_i = t.v;   dec_src1_i = t.s1;  dec_src1_used_i = t.s1u;
        dec_src2_i  = t.s2;  dec_src2_used_i = t.s2u;
        dec_wr_i    = t.wr;  dec_dst_i = t.dst;  dec_branch_i = t.br;
        alu_br_valid_i = t.abv; alu_br_taken_i = t.abt;
        wb_valid_i  = t.wbv; wb_dst_i = t.wbd;
    endtask

    task automatic check(input string nm, input logic [4:0] ctl,
                         input logic [15:0] busy, input logic [3:0] stall);
        logic [24:0] act, exp;
        act = {fetch_keep_o, decode_keep_o, reg_nope_o, flush_o, issue_o, busy_map_o, stall_cnt_o};
        exp = {ctl, busy, stall};
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got ctl=%b busy=%h stall=%0d, want ctl=%b busy=%h stall=%0d",
                     nm, act[24:20], act[19:4], act[3:0], ctl, busy, stall);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t idle, h;

    initial begin
        idle = '{default: '0};
        //   v s1 u s2 u wr dst br abv abt wbv wbd  ctl        busy     stall
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 16'h0000, 0);  // idle after reset
        add(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 5'b00001, 16'h0000, 0);  // write r3
        add(1, 3, 1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 5'b11100, 16'h0008, 0);  // RAW on r3
        add(1, 3, 1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 5'b11100, 16'h0008, 1);
        add(1, 3, 1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 5'b11100, 16'h0008, 2);
        add(1, 3, 1, 0, 0, 1, 4, 0, 0, 0, 1, 3, 5'b00001, 16'h0008, 3);  // wb bypass releases
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 16'h0010, 3);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 5'b00001, 16'h0010, 3);  // write r0
        add(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 16'h0010, 3);  // read r0
        add(1, 4, 0, 4, 1, 0, 0, 0, 0, 0, 1, 4, 5'b00001, 16'h0010, 3);  // src2 bypass
        add(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 5'b00001, 16'h0000, 3);  // branch; alu ignored
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 16'h0000, 3);  // BR_WAIT x4
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 16'h0000, 4);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 16'h0000, 5);
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 5'b11100, 16'h0000, 6);  // taken
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110, 16'h0000, 7);  // FLUSH x2
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110, 16'h0000, 7);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5'b00001, 16'h0000, 7);  // RUN, branch again
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b11100, 16'h0000, 7);  // taken w/o valid
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11100, 16'h0000, 8);  // not taken
        add(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 5, 5'b00001, 16'h0000, 9);  // set/clear r5
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 16'h0020, 9);
        add(1, 5, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 16'h0020, 9);  // unused sources
        add(0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 16'h0020, 9);  // not valid
        add(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100, 16'h0020, 9);  // stall on r5

        // Reset with random inputs: every output low
        arstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            h = idle;
            h.v = 1'($urandom); h.s1 = 4'($urandom); h.s1u = 1'($urandom);
            h.s2 = 4'($urandom); h.s2u = 1'($urandom); h.wr = 1'($urandom);
            h.dst = 4'($urandom); h.br = 1'($urandom); h.abv = 1'($urandom);
            h.abt = 1'($urandom); h.wbv = 1'($urandom); h.wbd = 4'($urandom);
            h.v = (i == 0) ? 1'b1 : h.v;
            drive(h);
            @(negedge clk);
            check($sformatf("reset_%0d", i), 5'b00000, 16'h0000, 4'd0);
            next_cycle();
        end
        drive(idle);
        arstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("vec_%0d", i), tbl[i].ctl, tbl[i].busy, tbl[i].stall);
            next_cycle();
        end

        // Keep stalling on r5 for 20 more cycles: counter saturates at 15
        h = tbl[tbl.size() - 1];
        drive(h);
        for (int i = 0; i < 20; i++) next_cycle();
        @(negedge clk);
        check("stall_saturate", 5'b11100, 16'h0020, 4'd15);
        next_cycle();
        h.wbv = 1'b1; h.wbd = 4'd5;
        drive(h);
        @(negedge clk);
        check("saturate_release", 5'b00001, 16'h0020, 4'd15);
        next_cycle();

        // Reset asserted mid-flush clears everything
        h = idle; h.v = 1'b1; h.wr = 1'b1; h.dst = 4'd7;
        drive(h); next_cycle();
        h = idle; h.v = 1'b1; h.br = 1'b1;
        drive(h); next_cycle();
        h = idle; h.v = 1'b1; h.abv = 1'b1; h.abt = 1'b1;
        drive(h); next_cycle();
        h = idle; h.v = 1'b1; h.s1 = 4'd7; h.s1u = 1'b1;
        drive(h);
        @(negedge clk);
        check("pre_reset_flush", 5'b00110, 16'h0080, 4'd15);
        #1 arstn = 1'b0;
        #1 check("async_reset_flush", 5'b00000, 16'h0000, 4'd0);
        #1 arstn = 1'b1;
        next_cycle();
        @(negedge clk);
        check("post_reset_issue", 5'b00001, 16'h0000, 4'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
